// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory controller and its arbiter.
package imem_ctrl_pkg;

  localparam int DefAddrBits  = 19;
  localparam int BytesPerWord = 4;

  localparam logic [2:0] LastRdCnt = 3'(BytesPerWord);
  localparam logic [2:0] LastWrCnt = 3'(BytesPerWord - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LD = 1'b1
  } grant_e;

endpackage

// File: rtl/imem_ctrl_if.sv
// Requester-side bundle: instruction fetch port and program-loader write port.
interface imem_ctrl_if #(
  parameter int RegBits = 32
);

  logic               if_req;
  logic [RegBits-1:0] if_addr;
  logic               if_ack;
  logic               if_err;
  logic [RegBits-1:0] if_rdata;
  logic               ld_req;
  logic [RegBits-1:0] ld_addr;
  logic [RegBits-1:0] ld_wdata;
  logic               ld_ack;
  logic               ld_err;

  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_wdata,
    input  if_ack, if_err, if_rdata, ld_ack, ld_err
  );

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, ld_wdata,
    output if_ack, if_err, if_rdata, ld_ack, ld_err
  );

endinterface

// File: rtl/imem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the requester not granted last time wins.
module rr_arb2
  import imem_ctrl_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_if_i,
  input  logic   req_ld_i,
  input  logic   accept_i,
  output logic   valid_o,
  output grant_e gnt_o
);

  grant_e last_q;

  // Grant selection
  always_comb begin
    valid_o = req_if_i | req_ld_i;
    if (req_if_i && req_ld_i) begin
      gnt_o = (last_q == GNT_IF) ? GNT_LD : GNT_IF;
    end else if (req_ld_i) begin
      gnt_o = GNT_LD;
    end else begin
      gnt_o = GNT_IF;
    end
  end

  // History only moves when the grant is actually taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= GNT_IF;
    end else if (accept_i && valid_o) begin
      last_q <= gnt_o;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Byte-serial sequencer sharing a single-port byte memory between fetch and loader ports.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int RegBits  = 32,
  parameter int AddrBits = DefAddrBits
) (
  input  logic                clk_i,
  input  logic                rst_i,
  imem_ctrl_if.slave          bus,
  output logic                busy_o,
  output logic [AddrBits-1:0] mem_addr_o,
  output logic                mem_we_o,
  output logic [7:0]          mem_wdata_o,
  input  logic [7:0]          mem_rdata_i
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_WR   = WR;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [AddrBits-1:0] base_q, base_d;
  logic [RegBits-1:0]  wdata_q, wdata_d;
  logic [RegBits-1:0]  asm_q, asm_d;
  grant_e              gnt_q, gnt_d;
  logic                err_q, err_d;

  logic                busy_q, mem_we_q, if_ack_q, if_err_q, ld_ack_q, ld_err_q;
  logic [AddrBits-1:0] mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic [RegBits-1:0]  if_rdata_q;

  logic                arb_valid, accept, mem_active;
  grant_e              arb_gnt;
  logic [RegBits-1:0]  req_addr;
  logic                unused_addr_hi;

  assign accept         = (state_q == S_IDLE);
  assign req_addr       = (arb_gnt == GNT_LD) ? bus.ld_addr : bus.if_addr;
  assign unused_addr_hi = ^req_addr[RegBits-1:AddrBits];

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_if_i (bus.if_req),
    .req_ld_i (bus.ld_req),
    .accept_i (accept),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt)
  );

  // Next-state logic; byte lanes are filled in as the registered read data arrives
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          base_d  = req_addr[AddrBits-1:0];
          wdata_d = bus.ld_wdata;
          cnt_d   = 3'd0;
          asm_d   = {RegBits{1'b0}};
          if (req_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = (arb_gnt == GNT_LD) ? S_WR : S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_q != 3'd0) begin
          asm_d = asm_q | (RegBits'(mem_rdata_i) << {cnt_q - 3'd1, 3'b000});
        end else begin
          asm_d = asm_q;
        end
        if (cnt_q == LastRdCnt) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR: begin
        if (cnt_q == LastWrCnt) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_active = (state_d == S_WR) || ((state_d == S_RD) && (cnt_d != LastRdCnt));

  // State and registered outputs, all derived from next-state so they align with state_q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      base_q      <= {AddrBits{1'b0}};
      wdata_q     <= {RegBits{1'b0}};
      asm_q       <= {RegBits{1'b0}};
      gnt_q       <= GNT_IF;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= {AddrBits{1'b0}};
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= {RegBits{1'b0}};
      ld_ack_q    <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      busy_q      <= (state_d != S_IDLE);
      mem_addr_q  <= mem_active ? (base_d + AddrBits'(cnt_d)) : {AddrBits{1'b0}};
      mem_we_q    <= (state_d == S_WR);
      mem_wdata_q <= (state_d == S_WR) ? 8'(wdata_d >> {cnt_d[1:0], 3'b000}) : 8'd0;
      if_ack_q    <= (state_d == S_RESP) && (gnt_d == GNT_IF);
      if_err_q    <= (state_d == S_RESP) && (gnt_d == GNT_IF) && err_d;
      if_rdata_q  <= ((state_d == S_RESP) && (gnt_d == GNT_IF) && !err_d) ? asm_d : {RegBits{1'b0}};
      ld_ack_q    <= (state_d == S_RESP) && (gnt_d == GNT_LD);
      ld_err_q    <= (state_d == S_RESP) && (gnt_d == GNT_LD) && err_d;
    end
  end

  assign busy_o       = busy_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.if_err   = if_err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.ld_ack   = ld_ack_q;
  assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl with a registered-read byte memory model.
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  localparam int AB = 19;

  typedef struct packed {
    logic        is_ld;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, mem_we;
  logic [AB-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  logic          pre_we = 1'b0;
  logic [AB-1:0] pre_addr = '0;
  logic [7:0]    pre_data = 8'd0;
  logic [7:0]    mem [0:(1<<AB)-1];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb [$];
  logic both_seen = 1'b0;
  logic mem_seen  = 1'b0;

  always #5 clk = ~clk;

  imem_ctrl_if #(.RegBits(32)) bus ();

  imem_ctrl #(.RegBits(32), .AddrBits(AB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic poke(input logic [AB-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_ack(output logic is_ld, output logic [31:0] rd, output logic er,
                          output int lat, output logic tmo);
    is_ld = 1'b0; rd = 32'd0; er = 1'b0; lat = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.if_ack && bus.ld_ack) both_seen = 1'b1;
      if (mem_we || (mem_addr != '0)) mem_seen = 1'b1;
      if (bus.if_ack || bus.ld_ack) begin
        is_ld = bus.ld_ack;
        rd    = bus.if_rdata;
        er    = bus.ld_ack ? bus.ld_err : bus.if_err;
        tmo   = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_mem_side: got %0h want 0", {busy, mem_we, mem_addr, mem_wdata});
    else pass_cnt++;
    total_cnt++;
    if ({bus.if_ack, bus.if_err, bus.ld_ack, bus.ld_err, bus.if_rdata} !== '0)
      $display("FAIL reset_req_side: got %0h want 0", {bus.if_ack, bus.if_err, bus.ld_ack, bus.ld_err, bus.if_rdata});
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic is_ld, er, tmo; logic [31:0] rd; int lat; exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'd0});
    sb.push_back('{1'b0, 1'b0, 32'h00100513});
    @(negedge clk);
    bus.if_addr = 32'h100; bus.ld_addr = 32'h210; bus.ld_wdata = 32'h12345678;
    bus.if_req = 1'b1; bus.ld_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(is_ld, rd, er, lat, tmo);
      if (is_ld) bus.ld_req = 1'b0; else bus.if_req = 1'b0;
      e = sb.pop_front();
      total_cnt++;
      if ({tmo, is_ld, er} !== {1'b0, e.is_ld, e.err})
        $display("FAIL conflict_order%0d: got tmo/ld/err %b%b%b want 0%b%b", k, tmo, is_ld, er, e.is_ld, e.err);
      else pass_cnt++;
      if (!e.is_ld) begin
        total_cnt++;
        if (rd !== e.rdata) $display("FAIL conflict_rdata: got %h want %h", rd, e.rdata);
        else pass_cnt++;
      end
    end
    for (int k = 0; k < 4; k++) sb.push_back('{(k % 2 == 0), 1'b0, (k % 2 == 0) ? 32'd0 : 32'h00100513});
    @(negedge clk);
    bus.if_req = 1'b1; bus.ld_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(is_ld, rd, er, lat, tmo);
      if (k == 3) begin bus.if_req = 1'b0; bus.ld_req = 1'b0; end
      e = sb.pop_front();
      total_cnt++;
      if ({tmo, is_ld} !== {1'b0, e.is_ld})
        $display("FAIL alternate%0d: got tmo/ld %b%b want 0%b", k, tmo, is_ld, e.is_ld);
      else pass_cnt++;
    end
    total_cnt++;
    if ({mem[AB'(32'h213)], mem[AB'(32'h212)], mem[AB'(32'h211)], mem[AB'(32'h210)]} !== 32'h12345678)
      $display("FAIL conflict_write: got %h want 12345678",
               {mem[AB'(32'h213)], mem[AB'(32'h212)], mem[AB'(32'h211)], mem[AB'(32'h210)]});
    else pass_cnt++;
  endtask

  task automatic test_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input string nm);
    logic is_ld, er, tmo; logic [31:0] rd; int lat; exp_t e;
    sb.push_back('{1'b0, 1'b0, exp_data});
    @(negedge clk);
    bus.if_addr = addr; bus.if_req = 1'b1;
    wait_ack(is_ld, rd, er, lat, tmo);
    bus.if_req = 1'b0;
    bus.if_addr = 32'hFFFF_FFFF;
    e = sb.pop_front();
    total_cnt++;
    if ({tmo, is_ld, er, rd} !== {1'b0, e.is_ld, e.err, e.rdata})
      $display("FAIL %s: got tmo=%b ld=%b err=%b rdata=%h want tmo=0 ld=0 err=0 rdata=%h", nm, tmo, is_ld, er, rd, e.rdata);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 6) $display("FAIL %s_latency: got %0d want 6", nm, lat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.if_ack, bus.if_rdata} !== 33'd0)
      $display("FAIL %s_pulse: got ack=%b rdata=%h want 0", nm, bus.if_ack, bus.if_rdata);
    else pass_cnt++;
  endtask

  task automatic test_write_readback();
    logic is_ld, er, tmo; logic [31:0] rd; int lat; exp_t e;
    sb.push_back('{1'b1, 1'b0, 32'd0});
    @(negedge clk);
    bus.ld_addr = 32'h200; bus.ld_wdata = 32'hDEADBEEF; bus.ld_req = 1'b1;
    wait_ack(is_ld, rd, er, lat, tmo);
    bus.ld_req = 1'b0;
    e = sb.pop_front();
    total_cnt++;
    if ({tmo, is_ld, er} !== {1'b0, e.is_ld, e.err})
      $display("FAIL write_ack: got tmo/ld/err %b%b%b want 0%b%b", tmo, is_ld, er, e.is_ld, e.err);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 5) $display("FAIL write_latency: got %0d want 5", lat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem[AB'(32'h203)], mem[AB'(32'h202)], mem[AB'(32'h201)], mem[AB'(32'h200)]} !== 32'hDEADBEEF)
      $display("FAIL write_bytes: got %h want deadbeef",
               {mem[AB'(32'h203)], mem[AB'(32'h202)], mem[AB'(32'h201)], mem[AB'(32'h200)]});
    else pass_cnt++;
    test_fetch(32'h200, 32'hDEADBEEF, "readback");
  endtask

  task automatic test_misaligned();
    logic is_ld, er, tmo; logic [31:0] rd; int lat; exp_t e;
    sb.push_back('{1'b0, 1'b1, 32'd0});
    sb.push_back('{1'b1, 1'b1, 32'd0});
    mem_seen = 1'b0;
    @(negedge clk);
    bus.if_addr = 32'h102; bus.if_req = 1'b1;
    wait_ack(is_ld, rd, er, lat, tmo);
    bus.if_req = 1'b0;
    e = sb.pop_front();
    total_cnt++;
    if ({tmo, is_ld, er, rd, lat} !== {1'b0, e.is_ld, e.err, e.rdata, 32'd1})
      $display("FAIL misaligned_fetch: got tmo=%b ld=%b err=%b rdata=%h lat=%0d want 0 0 1 0 1", tmo, is_ld, er, rd, lat);
    else pass_cnt++;
    @(negedge clk);
    bus.ld_addr = 32'h201; bus.ld_wdata = 32'h0BAD0BAD; bus.ld_req = 1'b1;
    wait_ack(is_ld, rd, er, lat, tmo);
    bus.ld_req = 1'b0;
    e = sb.pop_front();
    total_cnt++;
    if ({tmo, is_ld, er, lat} !== {1'b0, e.is_ld, e.err, 32'd1})
      $display("FAIL misaligned_write: got tmo=%b ld=%b err=%b lat=%0d want 0 1 1 1", tmo, is_ld, er, lat);
    else pass_cnt++;
    total_cnt++;
    if (mem_seen !== 1'b0) $display("FAIL misaligned_mem_idle: got %b want 0", mem_seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic is_ld, er, tmo; logic [31:0] rd; int lat;
    int exp_lat [4] = '{6, 7, 5, 6};
    @(negedge clk);
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        @(negedge clk);
        bus.ld_addr = 32'h220; bus.ld_wdata = 32'hCAFEF00D; bus.ld_req = 1'b1;
      end
      wait_ack(is_ld, rd, er, lat, tmo);
      if (k == 1) bus.if_req = 1'b0;
      if (k == 3) bus.ld_req = 1'b0;
      total_cnt++;
      if ({tmo, is_ld} !== {1'b0, (k >= 2)} || lat !== exp_lat[k])
        $display("FAIL back_to_back%0d: got tmo=%b ld=%b lat=%0d want 0 %b %0d", k, tmo, is_ld, lat, (k >= 2), exp_lat[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (both_seen !== 1'b0) $display("FAIL dual_ack: got %b want 0", both_seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    logic is_ld, er, tmo; logic [31:0] rd; int lat;
    @(negedge clk);
    bus.ld_addr = 32'h300; bus.ld_wdata = 32'h11223344; bus.ld_req = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, mem_we, mem_addr, mem_wdata, bus.ld_ack} !== '0)
      $display("FAIL reset_async: got %0h want 0", {busy, mem_we, mem_addr, mem_wdata, bus.ld_ack});
    else pass_cnt++;
    @(negedge clk);
    bus.ld_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(is_ld, rd, er, lat, tmo);
    total_cnt++;
    if (tmo !== 1'b1) $display("FAIL reset_no_ack: got ack ld=%b want none", is_ld);
    else pass_cnt++;
    total_cnt++;
    if ({mem[AB'(32'h303)], mem[AB'(32'h302)], mem[AB'(32'h301)], mem[AB'(32'h300)]} !== 32'hAAAA3344)
      $display("FAIL partial_write: got %h want aaaa3344",
               {mem[AB'(32'h303)], mem[AB'(32'h302)], mem[AB'(32'h301)], mem[AB'(32'h300)]});
    else pass_cnt++;
    test_fetch(32'h300, 32'hAAAA3344, "after_reset_fetch");
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.ld_req = 1'b0; bus.ld_addr = 32'd0; bus.ld_wdata = 32'd0;
    test_reset();
    poke(AB'(32'h100), 8'h13); poke(AB'(32'h101), 8'h05);
    poke(AB'(32'h102), 8'h10); poke(AB'(32'h103), 8'h00);
    poke(AB'(32'h7FFFC), 8'h01); poke(AB'(32'h7FFFD), 8'h02);
    poke(AB'(32'h7FFFE), 8'h03); poke(AB'(32'h7FFFF), 8'h04);
    for (int i = 0; i < 4; i++) begin
      poke(AB'(32'h200 + i), 8'h55);
      poke(AB'(32'h300 + i), 8'hAA);
    end
    @(negedge clk);
    rst = 1'b0;
    test_conflict();
    test_fetch(32'h100, 32'h00100513, "fetch");
    test_write_readback();
    test_misaligned();
    test_fetch(32'h0007FFFC, 32'h04030201, "top_fetch");
    test_fetch(32'h8007FFFC, 32'h04030201, "top_fetch_hi");
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
